// File: rtl/data_mem_resp_if.sv
// Load/store port between the core and the data-memory responder.
// The core drives requests through the master modport; the responder answers through slave.
interface data_mem_resp_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              mem_r_req_i;
  logic [ADDR_W-1:0] mem_r_addr_i;
  logic              mem_r_ready_o;
  logic              mem_r_valid_o;
  logic [DATA_W-1:0] mem_r_data_o;
  logic              mem_w_req_i;
  logic [ADDR_W-1:0] mem_w_addr_i;
  logic [DATA_W-1:0] mem_w_data_i;

  modport master (
    output mem_r_req_i, mem_r_addr_i, mem_w_req_i, mem_w_addr_i, mem_w_data_i,
    input  mem_r_ready_o, mem_r_valid_o, mem_r_data_o
  );

  modport slave (
    input  mem_r_req_i, mem_r_addr_i, mem_w_req_i, mem_w_addr_i, mem_w_data_i,
    output mem_r_ready_o, mem_r_valid_o, mem_r_data_o
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: single-cycle writes, reads returned after RD_LAT cycles
// with a one-cycle valid strobe. Array contents survive reset.
module data_mem_resp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("data_mem_resp: RD_LAT must be in the range 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              accept;
  logic              capture;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;

  // Write-first read port: a write landing on the capture edge wins over the array.
  always_comb begin
    accept  = bus.mem_r_req_i && ready_q;
    rd_addr = accept ? bus.mem_r_addr_i : addr_q;
    if (bus.mem_w_req_i && (bus.mem_w_addr_i == rd_addr)) begin
      rd_word = bus.mem_w_data_i;
    end else begin
      rd_word = mem[rd_addr];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    capture = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          addr_d = bus.mem_r_addr_i;
          if (RD_LAT == 1) begin
            state_d = RESP;
            capture = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = 4'd0;
          state_d = RESP;
          capture = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (capture) begin
      data_d = rd_word;
    end

    valid_d = (state_d == RESP);
    ready_d = (state_d != WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  // The array has no reset so its contents persist; writes are gated while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_w_req_i) begin
      mem[bus.mem_w_addr_i] <= bus.mem_w_data_i;
    end
  end

  assign bus.mem_r_ready_o = ready_q;
  assign bus.mem_r_valid_o = valid_q;
  assign bus.mem_r_data_o  = data_q;

  a_valid_implies_ready : assert property (
    @(posedge clk) disable iff (rst) valid_q |-> ready_q
  );

  a_wait_counter_live : assert property (
    @(posedge clk) disable iff (rst)
      (state_q == WAIT) |-> ((cnt_q >= 4'd1) && (cnt_q <= 4'd14))
  );

  a_ready_tracks_state : assert property (
    @(posedge clk) disable iff (rst) ready_q == (state_q != WAIT)
  );

endmodule
